// File: rtl/twiddle_mult_stage.sv
// Twiddle ROM consumer: per-sample index generation and 3-cycle complex multiply.
// Define TWMULT_ROUND_EN for round-half-up; otherwise results truncate toward -inf.
module twiddle_mult_stage #(
    parameter int DW        = 16,
    parameter int WW        = 9,
    parameter int ADDR_W    = 1,
    parameter int GROUP_LEN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 frame_start,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic signed [WW-1:0] w_r,
    input  logic signed [WW-1:0] w_i,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i
);
    localparam int PW = DW + WW;
    localparam int SW = PW + 1;
    localparam int GW = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (DW - 1)));
    localparam logic signed [SW-1:0] RND  = SW'(2 ** (WW - 3));

    logic [GW-1:0]     grp_q, grp_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic                 v1_q;
    logic signed [DW-1:0] ar_q, ai_q;
    logic signed [WW-1:0] wr_q, wi_q;

    logic                 v2_q;
    logic signed [PW-1:0] prr_q, pii_q, pri_q, pir_q;

    logic                 ov_q;
    logic signed [DW-1:0] or_q, oi_q;

    // A frame-start sample consumes index 0, so the counters load one step past it
    always_comb begin
        grp_d = grp_q;
        idx_d = idx_q;
        if (in_valid) begin
            if (frame_start) begin
                if (GROUP_LEN == 1) begin
                    grp_d = '0;
                    idx_d = ADDR_W'(1);
                end else begin
                    grp_d = GW'(1);
                    idx_d = '0;
                end
            end else if (grp_q == GW'(GROUP_LEN - 1)) begin
                grp_d = '0;
                idx_d = idx_q + ADDR_W'(1);
            end else begin
                grp_d = grp_q + GW'(1);
            end
        end
    end

    assign rom_addr = (in_valid && frame_start) ? '0 : idx_q;

    function automatic logic signed [DW-1:0] scale(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] t;
        t = s;
`ifdef TWMULT_ROUND_EN
        t = t + RND;
`endif
        t = t >>> (WW - 2);
        if (t > MAXV) t = MAXV;
        else if (t < MINV) t = MINV;
        return DW'(t);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q <= '0;
            idx_q <= '0;
        end else begin
            grp_q <= grp_d;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            ar_q  <= '0;
            ai_q  <= '0;
            wr_q  <= '0;
            wi_q  <= '0;
            v2_q  <= 1'b0;
            prr_q <= '0;
            pii_q <= '0;
            pri_q <= '0;
            pir_q <= '0;
            ov_q  <= 1'b0;
            or_q  <= '0;
            oi_q  <= '0;
        end else begin
            v1_q  <= in_valid;
            ar_q  <= in_r;
            ai_q  <= in_i;
            wr_q  <= w_r;
            wi_q  <= w_i;
            v2_q  <= v1_q;
            prr_q <= PW'(ar_q) * PW'(wr_q);
            pii_q <= PW'(ai_q) * PW'(wi_q);
            pri_q <= PW'(ar_q) * PW'(wi_q);
            pir_q <= PW'(ai_q) * PW'(wr_q);
            ov_q  <= v2_q;
            if (v2_q) begin
                or_q <= scale(SW'(prr_q) - SW'(pii_q));
                oi_q <= scale(SW'(pri_q) + SW'(pir_q));
            end
        end
    end

    assign out_valid = ov_q;
    assign out_r     = or_q;
    assign out_i     = oi_q;
endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Bench for twiddle_mult_stage: directed vectors, addressing, reset and
// randomized traffic against an arithmetic reference model.
module tb_twiddle_mult_stage;
    localparam int DW = 16;
    localparam int WW = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, frame_start;
    logic signed [DW-1:0] in_r, in_i;
    logic [0:0]           rom_addr;
    logic [1:0]           rom_addr2;
    logic signed [WW-1:0] w_r, w_i, wr_drv, wi_drv;
    logic                 rom_mode;
    logic signed [WW-1:0] rom_r [2];
    logic signed [WW-1:0] rom_i [2];
    logic                 out_valid, u2_ov;
    logic signed [DW-1:0] out_r, out_i, u2_or, u2_oi;

    always #5 clk = ~clk;

    assign w_r = rom_mode ? rom_r[rom_addr] : wr_drv;
    assign w_i = rom_mode ? rom_i[rom_addr] : wi_drv;

    twiddle_mult_stage #(.DW(DW), .WW(WW), .ADDR_W(1), .GROUP_LEN(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .in_r(in_r), .in_i(in_i), .rom_addr(rom_addr), .w_r(w_r), .w_i(w_i),
        .out_valid(out_valid), .out_r(out_r), .out_i(out_i)
    );

    twiddle_mult_stage #(.DW(DW), .WW(WW), .ADDR_W(2), .GROUP_LEN(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .in_r(in_r), .in_i(in_i), .rom_addr(rom_addr2), .w_r(wr_drv), .w_i(wi_drv),
        .out_valid(u2_ov), .out_r(u2_or), .out_i(u2_oi)
    );

    typedef struct {
        int t;
        int r;
        int i;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   s      = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_r = 0;
    int   last_i = 0;

    function automatic int ref_part(input longint x);
        longint y;
`ifdef TWMULT_ROUND_EN
        x = x + 64;
`endif
        y = x / 128;
        if (x < 0 && (x % 128) != 0) y = y - 1;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic fs, input int ar, input int ai);
        int   ea, e2, wr, wi;
        exp_t e;
        in_valid    = v;
        frame_start = fs;
        in_r        = DW'(ar);
        in_i        = DW'(ai);
        #1;
        ea = (v && fs) ? 0 : (s / 2) % 2;
        e2 = (v && fs) ? 0 : s % 4;
        chk("rom_addr", rom_addr, ea);
        chk("rom_addr_g1", rom_addr2, e2);
        if (v) begin
            if (fs) s = 0;
            wr = rom_mode ? int'(rom_r[ea]) : int'(wr_drv);
            wi = rom_mode ? int'(rom_i[ea]) : int'(wi_drv);
            e.t = cyc + 3;
            e.r = ref_part(longint'(ar) * wr - longint'(ai) * wi);
            e.i = ref_part(longint'(ar) * wi + longint'(ai) * wr);
            q.push_back(e);
            s++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].t == cyc) begin
            e = q.pop_front();
            chk("out_valid", out_valid, 1);
            chk("out_r", out_r, e.r);
            chk("out_i", out_i, e.i);
            last_r = e.r;
            last_i = e.i;
        end else begin
            chk("out_valid_idle", out_valid, 0);
            chk("out_r_hold", out_r, last_r);
            chk("out_i_hold", out_i, last_i);
        end
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_addr_g1", rom_addr2, 0);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        #4;
        @(posedge clk);
        #3;
        rst = 1'b0;
        q.delete();
        s      = 0;
        last_r = 0;
        last_i = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        in_r        = '0;
        in_i        = '0;
        rom_mode    = 1'b0;
        wr_drv      = 9'sd128;
        wi_drv      = '0;
        rom_r[0]    = '0;
        rom_r[1]    = '0;
        rom_i[0]    = '0;
        rom_i[1]    = '0;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_out_r", out_r, 0);
        chk("init_rom_addr", rom_addr, 0);
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // identity
        wr_drv = 9'sd128;
        wi_drv = 9'sd0;
        step(1, 0, 100, -50);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("ident_valid", out_valid, 1);
        chk("ident_r", out_r, 100);
        chk("ident_i", out_i, -50);

        // multiply by -j
        wr_drv = 9'sd0;
        wi_drv = -9'sd128;
        step(1, 0, 100, -50);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("negj_r", out_r, -50);
        chk("negj_i", out_i, -100);

        // saturation, back-to-back
        wr_drv = -9'sd128;
        wi_drv = 9'sd0;
        step(1, 0, -32768, 0);
        wr_drv = 9'sd0;
        wi_drv = -9'sd128;
        step(1, 0, -32768, -32768);
        step(0, 0, 0, 0);
        chk("sat1_r", out_r, 32767);
        chk("sat1_i", out_i, 0);
        step(0, 0, 0, 0);
        chk("sat2_r", out_r, -32768);
        chk("sat2_i", out_i, 32767);

        // rounding
        wr_drv = 9'sd64;
        wi_drv = 9'sd0;
        step(1, 0, 1, 0);
        step(1, 0, -1, 0);
        step(0, 0, 0, 0);
`ifdef TWMULT_ROUND_EN
        chk("round_pos", out_r, 1);
`else
        chk("round_pos", out_r, 0);
`endif
        step(0, 0, 0, 0);
`ifdef TWMULT_ROUND_EN
        chk("round_neg", out_r, 0);
`else
        chk("round_neg", out_r, -1);
`endif
        step(0, 0, 0, 0);

        // addressing: gap after 3rd sample, then frame restart on 4th
        mid_reset();
        for (int k = 0; k < 6; k++) begin
            step(1, 0, k, -k);
            if (k == 2) step(0, 0, 0, 0);
        end
        mid_reset();
        for (int k = 0; k < 6; k++) step(1, (k == 3), 10 * k, k);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);

        // randomized traffic through the ROM
        rom_mode = 1'b1;
        rom_r[0] = WW'($urandom);
        rom_i[0] = WW'($urandom);
        rom_r[1] = -9'sd128;
        rom_i[1] = WW'($urandom);
        for (int k = 0; k < 300; k++) begin
            int ar, ai;
            ar = int'($signed(16'($urandom)));
            ai = int'($signed(16'($urandom)));
            if ($urandom_range(0, 9) == 0) ar = -32768;
            if ($urandom_range(0, 9) == 0) ai = 32767;
            if (k == 150) begin
                mid_reset();
                rom_r[0] = WW'($urandom);
                rom_i[1] = WW'($urandom);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, ar, ai);
        end
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
